// File: rtl/countdown_timer_8bit_pkg.sv
// Shared definitions for the 8-bit countdown timer: the state encoding
// used by the FSM and the default counter width.
package countdown_timer_8bit_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_timer_8bit_if.sv
// Control/status bundle of the countdown timer. The master side drives
// enable, load and start; the slave side (the timer) returns the count
// and its status flags.
interface countdown_timer_8bit_if
    import countdown_timer_8bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             zero;
    logic             done;

    modport master (
        output en, load, load_val, start,
        input  q, busy, zero, done
    );

    modport slave (
        input  en, load, load_val, start,
        output q, busy, zero, done
    );

endinterface

// File: rtl/countdown_timer_8bit_dec.sv
// Borrow-chain decrementer: each bit toggles when every lower bit is zero,
// so the result is q - 1 (modulo 2^WIDTH) with no carry adder.
module dec_8bit
    import countdown_timer_8bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    assign q_next[0] = ~q[0];

    // Bit i borrows when all bits below it are zero.
    for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
        assign q_next[i] = q[i] ^ ~|q[i-1:0];
    end

endmodule

// File: rtl/countdown_timer_8bit.sv
// Loadable down counter with start/expire control and a one-cycle done
// pulse on expiry. Optional feature macro: COUNTDOWN_AUTORELOAD_EN, which
// reloads the count on expiry and keeps running instead of stopping.
module countdown_timer_8bit
    import countdown_timer_8bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_timer_8bit_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] q_dec;
    logic             done_reg;

    dec_8bit #(.WIDTH(WIDTH)) u_dec (
        .q      (q_reg),
        .q_next (q_dec)
    );

    // FSM and datapath registers; load overrides start, start overrides en.
    // Expiry is taken at q == 1 so RUN never decrements through zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            q_reg      <= '0;
            reload_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (bus.load) begin
                q_reg      <= bus.load_val;
                reload_reg <= bus.load_val;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && (q_reg != '0)) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (bus.en) begin
                            if (q_reg == ONE) begin
                                done_reg <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                                q_reg    <= reload_reg;
`else
                                q_reg    <= '0;
                                state    <= EXPIRED;
`endif
                            end else begin
                                q_reg <= q_dec;
                            end
                        end
                    end
                    EXPIRED: begin
                        if (bus.start && (reload_reg != '0)) begin
                            q_reg <= reload_reg;
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.q    = q_reg;
    assign bus.busy = (state == RUN);
    assign bus.zero = (q_reg == '0);
    assign bus.done = done_reg;

endmodule

// File: tb/tb_countdown_timer_8bit.sv
// Directed bench for countdown_timer_8bit: reset, countdown, enable gating,
// zero start, restart, load priority and (when built with
// COUNTDOWN_AUTORELOAD_EN) periodic auto-reload.
module tb_countdown_timer_8bit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    countdown_timer_8bit_if bus ();

    countdown_timer_8bit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    // Drive one set of inputs, take one rising edge, return 1 time unit later.
    task automatic applyStimulus(input logic ld, input logic [7:0] lv,
                                 input logic st, input logic e);
        bus.load     = ld;
        bus.load_val = lv;
        bus.start    = st;
        bus.en       = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] eq, input logic eb,
                            input logic ed);
        checkOutput({tag, " q"},    32'(bus.q),    32'(eq));
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'(eb));
        checkOutput({tag, " done"}, 32'(bus.done), 32'(ed));
        checkOutput({tag, " zero"}, 32'(bus.zero), 32'(eq == 8'd0));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'd0;
        bus.start    = 1'b0;

        // Reset state
        #3;
        checkAll("reset", 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

`ifndef COUNTDOWN_AUTORELOAD_EN
        // Basic countdown from 3 to expiry
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
        checkAll("basic load", 8'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        checkAll("basic start", 8'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("basic e1", 8'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("basic e2", 8'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("basic e3", 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("basic expired en", 8'd0, 1'b0, 1'b0);

        // Restart from EXPIRED restores the reload value
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("restart e1", 8'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("restart expire", 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        checkAll("restart start", 8'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("restart e1b", 8'd1, 1'b1, 1'b0);
`else
        // Auto-reload: load 4, start, 12 enabled edges
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        checkAll("auto start", 8'd4, 1'b1, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
            checkAll($sformatf("auto e%0d", e),
                     (e % 4 == 0) ? 8'd4 : 8'(4 - (e % 4)),
                     1'b1, (e % 4 == 0));
        end
`endif

        // Enable gating, start ignored in RUN
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("gate en1", 8'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
        checkAll("gate en0a", 8'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
        checkAll("gate en0b", 8'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("gate en1b", 8'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        checkAll("gate start in run", 8'd3, 1'b1, 1'b0);

        // Zero start is ignored
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        checkAll("zero start", 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("zero en", 8'd0, 1'b0, 1'b0);

        // Load beats expiry on the same edge
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("prio at one", 8'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h80, 1'b0, 1'b1);
        checkAll("prio load", 8'h80, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("prio idle en", 8'h80, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a count
        applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        end
        checkAll("midcount", 8'h3B, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkAll("async reset", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        checkAll("post reset", 8'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer_8bit.md
# countdown_timer_8bit

Loadable 8-bit down counter with start/expire control, for timeouts and fixed-length delays. It counts from a loaded value toward zero on enabled clock edges and flags expiry with a one-cycle `done` pulse. It sits beside the 8-bit up counter in the sequential-logic library and shares its enable and active-low reset semantics. Decrement uses the borrow-chain form: bit i toggles when all lower bits are zero.

## Interface
- `WIDTH`, default 8: counter width. The block is specified and verified at 8 only.
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `en`  input  1  count enable; one decrement per enabled edge while running
- `load`  input  1  load `load_val` into the counter and the reload register
- `load_val`  input  8  value to load
- `start`  input  1  begin counting
- `q`  output  8  current count
- `busy`  output  1  high while in RUN
- `zero`  output  1  high when `q == 0` (combinational from `q`)
- `done`  output  1  registered one-cycle expiry pulse

## Operation
- States (shared enum): IDLE, RUN, EXPIRED.
- Reset (`reset` = 0, asynchronous, takes effect immediately, including mid-count):
  - state IDLE, `q` = 0, reload register = 0
  - `busy` = 0, `done` = 0, `zero` = 1
- Priority per edge: `load` > `start` > `en`.
- `load` in any state:
  - `q` <= `load_val`, reload register <= `load_val`
  - state -> IDLE, `done` = 0 next cycle
- IDLE:
  - `start` with `q` != 0 -> RUN.
  - `start` with `q` == 0 is ignored and stays IDLE.
  - `en` has no effect.
- RUN:
  - `en` = 1 and `q` > 1: `q` <= `q` - 1.
  - `en` = 1 and `q` == 1: expiry. `done` = 1 for exactly the next cycle. Without auto-reload, `q` <= 0 and state -> EXPIRED.
  - `en` = 0: hold `q` and state.
  - `start` is ignored.
- EXPIRED:
  - `q` holds 0, `busy` = 0.
  - `start` -> `q` <= reload value, state -> RUN.
  - `en` has no effect.
- Width rule: 8-bit unsigned. `q` never wraps below 0, because expiry occurs at `q` == 1 and RUN is never entered with `q` == 0.
- Simultaneous `load` and expiry on the same edge: `load` wins and `done` stays 0.

## Timing
- `load` sampled at edge k: `q` = `load_val` after edge k.
- `start` sampled at edge k: `busy` = 1 after edge k. The start edge does not decrement; the first decrement is at the first `en` edge after k.
- Load N, start at edge 0, `en` held high: `q` = N-1 after edge 1, ..., and `done` = 1 after edge N.
  - `done` is high for exactly one cycle.
  - `busy` falls after edge N (without auto-reload).
- `done` is registered and has no combinational path from inputs. `zero` is combinational from `q` only.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined:
  - On expiry, `q` <= reload value instead of 0 and the state stays RUN.
  - `done` still pulses one cycle.
  - Expiry period is N enabled cycles for reload value N.
  - EXPIRED is unreachable.
- Not defined: behaviour as in Operation; the counter stops in EXPIRED.

## Structure
- Shared package/include holds:
  - the state encoding (IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2)
  - the `WIDTH` default constant
- One sub-module, `dec_8bit`: combinational borrow-chain decrementer, `q_next[i] = q[i] ^ ~|q[i-1:0]`, with `q_next[0] = ~q[0]`. The FSM and registers stay in the top module.

## Test plan
- Reset mid-count: load 0x40, start, run 5 enabled cycles, assert `reset` = 0 between edges -> `q` = 0, `busy` = 0, `done` = 0 immediately, without waiting for a clock edge.
- Basic countdown: load 3, start, `en` = 1 -> `q` = 2, 1, 0 on successive edges; `done` high one cycle after the third enabled edge; `busy` = 0; state EXPIRED.
- Enable gating: load 5, start, toggle `en` 1,0,0,1 -> `q` = 4, 4, 4, 3; `done` stays 0.
- Zero start / restart:
  - load 0, start -> stays IDLE, `busy` = 0.
  - load 2, count to expiry, then start -> `q` = 2, `busy` = 1.
- Load priority: in RUN at `q` = 1 with `en` = 1, assert `load` with `load_val` = 0x80 on the same edge -> `q` = 0x80, IDLE, `done` = 0.
- With `COUNTDOWN_AUTORELOAD_EN`: load 4, start, `en` = 1 for 12 edges -> `done` pulses after edges 4, 8 and 12; `q` sequence is 3,2,1,4,3,2,1,4,...; `busy` stays 1.
